// File: rtl/period_avg_lock_pkg.sv
// Shared types and constants for the period averaging / lock detector.
package period_avg_lock_pkg;

  localparam int CNT_W     = 9;
  localparam int SUM_W     = 11;
  localparam int WIN_DEPTH = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_FILL   = 2'd1;
  localparam state_t ST_TRACK  = 2'd2;
  localparam state_t ST_LOCKED = 2'd3;

  // Unsigned magnitude of the difference between two period counts.
  function automatic logic [CNT_W-1:0] abs_diff(input logic [CNT_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
    if (a >= b) begin
      abs_diff = a - b;
    end else begin
      abs_diff = b - a;
    end
  endfunction

endpackage

// File: rtl/period_avg_lock_if.sv
// Upstream period-counter inputs and averaged/lock status outputs.
interface period_avg_lock_if;
  import period_avg_lock_pkg::*;

  logic [CNT_W-1:0] count_in;
  logic             en_in;
  logic [CNT_W-1:0] avg_out;
  logic             avg_valid;
  logic             locked;
  logic             sample_stb;

  modport master (
    output count_in, en_in,
    input  avg_out, avg_valid, locked, sample_stb
  );

  modport slave (
    input  count_in, en_in,
    output avg_out, avg_valid, locked, sample_stb
  );

endinterface

// File: rtl/period_avg_lock_window.sv
// Four-deep sample window with running sum; avg holds its value across clear.
module period_window
  import period_avg_lock_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             clear,
  input  logic [CNT_W-1:0] din,
  output logic [SUM_W-1:0] sum,
  output logic [CNT_W-1:0] avg
);

  logic [CNT_W-1:0] win_r [WIN_DEPTH];
  logic [SUM_W-1:0] sum_r;
  logic [CNT_W-1:0] avg_r;
  logic [SUM_W-1:0] sum_nxt_s;

  // Next running sum: add the incoming sample, drop the oldest.
  always_comb begin
    sum_nxt_s = sum_r + {{(SUM_W-CNT_W){1'b0}}, din}
                      - {{(SUM_W-CNT_W){1'b0}}, win_r[WIN_DEPTH-1]};
  end

  // Window shift, sum and average registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < WIN_DEPTH; i++) begin
        win_r[i] <= '0;
      end
      sum_r <= '0;
      avg_r <= '0;
    end else if (clear) begin
      for (int i = 0; i < WIN_DEPTH; i++) begin
        win_r[i] <= '0;
      end
      sum_r <= '0;
    end else if (push) begin
      for (int i = WIN_DEPTH-1; i > 0; i--) begin
        win_r[i] <= win_r[i-1];
      end
      win_r[0] <= din;
      sum_r    <= sum_nxt_s;
      avg_r    <= sum_nxt_s[SUM_W-1 -: CNT_W];
    end else begin
      sum_r <= sum_r;
    end
  end

  assign sum = sum_r;
  assign avg = avg_r;

endmodule

// File: rtl/period_avg_lock.sv
// Detects new period samples, averages the last four and tracks lock
// when consecutive samples stay within TOL of the running average.
module period_avg_lock
  import period_avg_lock_pkg::*;
#(
  parameter int TOL    = 4,
  parameter int LOCK_N = 8
) (
  input logic              clk,
  input logic              rst,
  period_avg_lock_if.slave bus
);

  localparam logic [CNT_W-1:0] TOL_C  = CNT_W'(TOL);
  localparam logic [3:0]       LOCK_C = 4'(LOCK_N);

  logic [CNT_W-1:0] prev_count_r;
  logic [CNT_W-1:0] sample_r;
  logic             stb_r;
  state_t           state_r;
  logic [1:0]       fill_r;
  logic [3:0]       run_r;
  logic             valid_r;
  logic             locked_r;

  state_t           state_nxt_s;
  logic [1:0]       fill_nxt_s;
  logic [3:0]       run_nxt_s;
  logic             valid_nxt_s;
  logic             locked_nxt_s;

  logic             detect_s;
  logic             push_s;
  logic             clear_s;
  logic [SUM_W-1:0] win_sum_s;
  logic [CNT_W-1:0] win_avg_s;
  logic [CNT_W-1:0] avg_live_s;
  logic [CNT_W-1:0] dev_s;
  logic             in_tol_s;

  // A repeated identical period is indistinguishable from "no new period".
  assign detect_s = bus.en_in && (bus.count_in != prev_count_r);
  assign push_s   = stb_r && bus.en_in;
  assign clear_s  = !bus.en_in;

  period_window u_window (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .clear (clear_s),
    .din   (sample_r),
    .sum   (win_sum_s),
    .avg   (win_avg_s)
  );

  // Live average equals avg_out whenever the window is full, which is the
  // only time the tolerance result is consumed.
  assign avg_live_s = CNT_W'(win_sum_s >> 2'd2);
  assign dev_s      = abs_diff(sample_r, avg_live_s);
  assign in_tol_s   = (dev_s <= TOL_C);

  // Next-state logic for fill / track / lock.
  always_comb begin
    state_nxt_s  = state_r;
    fill_nxt_s   = fill_r;
    run_nxt_s    = run_r;
    valid_nxt_s  = valid_r;
    locked_nxt_s = locked_r;
    if (!bus.en_in) begin
      state_nxt_s  = ST_IDLE;
      fill_nxt_s   = 2'd0;
      run_nxt_s    = 4'd0;
      valid_nxt_s  = 1'b0;
      locked_nxt_s = 1'b0;
    end else if (stb_r) begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_FILL;
          fill_nxt_s  = 2'd1;
        end
        ST_FILL: begin
          if (fill_r == 2'd3) begin
            state_nxt_s = ST_TRACK;
            fill_nxt_s  = 2'd0;
            valid_nxt_s = 1'b1;
          end else begin
            fill_nxt_s = fill_r + 2'd1;
          end
        end
        ST_TRACK: begin
          if (in_tol_s) begin
            run_nxt_s = run_r + 4'd1;
            if ((run_r + 4'd1) == LOCK_C) begin
              state_nxt_s  = ST_LOCKED;
              locked_nxt_s = 1'b1;
            end else begin
              state_nxt_s = ST_TRACK;
            end
          end else begin
            run_nxt_s = 4'd0;
          end
        end
        ST_LOCKED: begin
          if (!in_tol_s) begin
            state_nxt_s  = ST_TRACK;
            run_nxt_s    = 4'd0;
            locked_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ST_LOCKED;
          end
        end
        default: begin
          state_nxt_s  = ST_IDLE;
          fill_nxt_s   = 2'd0;
          run_nxt_s    = 4'd0;
          valid_nxt_s  = 1'b0;
          locked_nxt_s = 1'b0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Sample capture and FSM state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_count_r <= '0;
      sample_r     <= '0;
      stb_r        <= 1'b0;
      state_r      <= ST_IDLE;
      fill_r       <= 2'd0;
      run_r        <= 4'd0;
      valid_r      <= 1'b0;
      locked_r     <= 1'b0;
    end else begin
      prev_count_r <= bus.count_in;
      stb_r        <= detect_s;
      if (detect_s) begin
        sample_r <= bus.count_in;
      end else begin
        sample_r <= sample_r;
      end
      state_r  <= state_nxt_s;
      fill_r   <= fill_nxt_s;
      run_r    <= run_nxt_s;
      valid_r  <= valid_nxt_s;
      locked_r <= locked_nxt_s;
    end
  end

  assign bus.avg_out    = win_avg_s;
  assign bus.avg_valid  = valid_r;
  assign bus.locked     = locked_r;
  assign bus.sample_stb = stb_r;

endmodule
